// File: rtl/mpccore_cost_argmin.sv
// -----------------------------------------------------------------------------
// mpccore_cost_argmin
//
// Purpose:
//   Cost-evaluation stage that sits behind the MPC weighted-error multiplier.
//   Each candidate switching vector receives TERMS signed error terms. The
//   absolute values of those terms are summed into a saturating cost. After
//   NUM_CAND candidates, the index and cost of the cheapest candidate are
//   published. This happens once per control period.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   ce         in   clock enable; ce=0 freezes all state and outputs
//   start      in   begin an evaluation (honoured only in IDLE)
//   din_valid  in   din carries a valid term this cycle
//   din        in   signed weighted error term [DIN_WIDTH-1:0]
//   busy       out  high from the accepted start until completion
//   done       out  one ce-cycle pulse when a result is published
//   best_idx   out  index of the minimum-cost candidate [IDX_WIDTH-1:0]
//   best_cost  out  cost of that candidate [ACC_WIDTH-1:0]
//   state_dbg  out  current FSM state (0=IDLE, 1=ACC, 2=DONE)
//
// Handshake:
//   There is no back-pressure toward the source. A term is consumed on every
//   rising edge where ce=1, din_valid=1 and the FSM is in ACC. The source
//   must not present more than NUM_CAND*TERMS valid terms per start.
// -----------------------------------------------------------------------------
module mpccore_cost_argmin #(
   parameter int DIN_WIDTH = 22,
   parameter int TERMS     = 3,
   parameter int NUM_CAND  = 27,
   parameter int ACC_WIDTH = 26,
   parameter int IDX_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ce,
   input  logic                 start,
   input  logic                 din_valid,
   input  logic [DIN_WIDTH-1:0] din,
   output logic                 busy,
   output logic                 done,
   output logic [IDX_WIDTH-1:0] best_idx,
   output logic [ACC_WIDTH-1:0] best_cost,
   output logic [1:0]           state_dbg
);

   localparam int TERM_W = (TERMS > 1) ? $clog2(TERMS) : 1;
   // The sum must hold the full accumulator plus one full-scale |din|
   // without losing the carry used to detect saturation.
   localparam int SUM_W  = ((ACC_WIDTH > DIN_WIDTH + 1) ? ACC_WIDTH : DIN_WIDTH + 1) + 1;

   localparam logic [TERM_W-1:0]    LAST_TERM = TERM_W'(TERMS - 1);
   localparam logic [IDX_WIDTH-1:0] LAST_CAND = IDX_WIDTH'(NUM_CAND - 1);
   localparam logic [ACC_WIDTH-1:0] ACC_MAX   = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 state_q,     state_d;
   logic [ACC_WIDTH-1:0]   acc_q,       acc_d;
   logic [TERM_W-1:0]      term_cnt_q,  term_cnt_d;
   logic [IDX_WIDTH-1:0]   cand_cnt_q,  cand_cnt_d;
   logic [ACC_WIDTH-1:0]   run_cost_q,  run_cost_d;
   logic [IDX_WIDTH-1:0]   run_idx_q,   run_idx_d;
   logic [ACC_WIDTH-1:0]   best_cost_q, best_cost_d;
   logic [IDX_WIDTH-1:0]   best_idx_q,  best_idx_d;

   // ---------------------------------------------------------------------------
   // Datapath: |din|, saturating accumulate and the running-best comparison
   // ---------------------------------------------------------------------------
   logic [DIN_WIDTH:0]     din_ext;
   logic [DIN_WIDTH:0]     abs_din;
   logic [SUM_W-1:0]       sum_wide;
   logic                   sum_sat;
   logic [ACC_WIDTH-1:0]   acc_sum;
   logic                   last_term;
   logic                   last_cand;
   logic                   new_best;
   logic [ACC_WIDTH-1:0]   cand_cost;
   logic [IDX_WIDTH-1:0]   cand_idx;

   always_comb begin
      // One extra bit so that |-2^(DIN_WIDTH-1)| is representable.
      din_ext   = {din[DIN_WIDTH-1], din};
      abs_din   = din_ext[DIN_WIDTH] ? ((~din_ext) + {{DIN_WIDTH{1'b0}}, 1'b1}) : din_ext;
      sum_wide  = SUM_W'(acc_q) + SUM_W'(abs_din);
      sum_sat   = |sum_wide[SUM_W-1:ACC_WIDTH];
      acc_sum   = sum_sat ? ACC_MAX : sum_wide[ACC_WIDTH-1:0];
      last_term = (term_cnt_q == LAST_TERM);
      last_cand = (cand_cnt_q == LAST_CAND);
      // Candidate 0 always seeds the best. After that, only a strictly smaller
      // cost wins, so ties keep the lower index.
      new_best  = (cand_cnt_q == '0) || (acc_sum < run_cost_q);
      cand_cost = new_best ? acc_sum    : run_cost_q;
      cand_idx  = new_best ? cand_cnt_q : run_idx_q;
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      term_cnt_d  = term_cnt_q;
      cand_cnt_d  = cand_cnt_q;
      run_cost_d  = run_cost_q;
      run_idx_d   = run_idx_q;
      best_cost_d = best_cost_q;
      best_idx_d  = best_idx_q;

      if (ce) begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d    = S_ACC;
                  acc_d      = '0;
                  term_cnt_d = '0;
                  cand_cnt_d = '0;
               end
            end

            S_ACC: begin
               if (din_valid) begin
                  if (!last_term) begin
                     acc_d      = acc_sum;
                     term_cnt_d = term_cnt_q + TERM_W'(1);
                  end else begin
                     acc_d      = '0;
                     term_cnt_d = '0;
                     run_cost_d = cand_cost;
                     run_idx_d  = cand_idx;
                     if (last_cand) begin
                        // Publish from the comparison result of this cycle.
                        // Do not use the registered running best.
                        state_d     = S_DONE;
                        cand_cnt_d  = '0;
                        best_cost_d = cand_cost;
                        best_idx_d  = cand_idx;
                     end else begin
                        cand_cnt_d = cand_cnt_q + IDX_WIDTH'(1);
                     end
                  end
               end
            end

            S_DONE: begin
               state_d = S_IDLE;
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         term_cnt_q  <= '0;
         cand_cnt_q  <= '0;
         run_cost_q  <= '0;
         run_idx_q   <= '0;
         best_cost_q <= '0;
         best_idx_q  <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         term_cnt_q  <= term_cnt_d;
         cand_cnt_q  <= cand_cnt_d;
         run_cost_q  <= run_cost_d;
         run_idx_q   <= run_idx_d;
         best_cost_q <= best_cost_d;
         best_idx_q  <= best_idx_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs are decoded from registered state. Because of this, ce=0 holds
   // every output steady.
   // ---------------------------------------------------------------------------
   assign busy      = (state_q == S_ACC);
   assign done      = (state_q == S_DONE);
   assign best_idx  = best_idx_q;
   assign best_cost = best_cost_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_mpccore_cost_argmin.sv
// -----------------------------------------------------------------------------
// tb_mpccore_cost_argmin
//
// Directed bench for mpccore_cost_argmin. Two instances share the same
// stimulus. dut_a uses the default 26-bit accumulator. dut_b uses a 22-bit
// accumulator so that the extreme-input case reaches saturation.
// -----------------------------------------------------------------------------
module tb_mpccore_cost_argmin;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        ce;
  logic        start;
  logic        din_valid;
  logic [21:0] din;

  logic        busy_a, done_a, busy_b, done_b;
  logic [4:0]  best_idx_a, best_idx_b;
  logic [25:0] best_cost_a;
  logic [21:0] best_cost_b;
  logic [1:0]  state_dbg_a, state_dbg_b;

  mpccore_cost_argmin dut_a (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .start     (start),
    .din_valid (din_valid),
    .din       (din),
    .busy      (busy_a),
    .done      (done_a),
    .best_idx  (best_idx_a),
    .best_cost (best_cost_a),
    .state_dbg (state_dbg_a)
  );

  mpccore_cost_argmin #(.ACC_WIDTH(22)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .start     (start),
    .din_valid (din_valid),
    .din       (din),
    .busy      (busy_b),
    .done      (done_b),
    .best_idx  (best_idx_b),
    .best_cost (best_cost_b),
    .state_dbg (state_dbg_b)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and compare helper
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;
  int done_cnt;
  int prev_idx;
  int prev_cost;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock. Count a done pulse that is seen while ce=1.
  task automatic step();
    logic pre;
    pre = done_a && ce;
    @(posedge clk);
    #1;
    if (pre) done_cnt++;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus patterns
  // ---------------------------------------------------------------------------
  localparam int K_RAMP = 0, K_SIGNED = 1, K_TIE = 2, K_EXTREME = 3;

  function automatic logic [21:0] term_val(input int kind, input int c, input int t);
    int v;
    v = 0;
    case (kind)
      K_RAMP:    v = (t == 0) ? (27 - c) : 0;
      K_SIGNED:  if (c == 5) v = (t == 0) ? -1 : ((t == 1) ? 1 : 0);
                 else        v = (t == 0) ? 10 : 0;
      K_TIE:     if (c == 3 || c == 7) v = (t == 0) ? 2 : ((t == 1) ? -2 : 0);
                 else                  v = (t == 0) ? 100 : 0;
      default:   v = -2097152;
    endcase
    return 22'(v);
  endfunction

  typedef struct {
    string name;
    int    kind;
    bit    gaps;
    int    exp_idx;
    int    exp_cost;
    int    exp_cost_b;
  } vec_t;

  vec_t vecs[5];

  // One full evaluation. It can add random ce/din_valid gaps and extra start pulses.
  task automatic run_eval(input vec_t v);
    done_cnt = 0;
    ce = 1'b1; start = 1'b1; din_valid = 1'b0; din = '0;
    step();
    start = 1'b0;
    check({v.name, "_busy_after_start"}, 32'(busy_a), 32'd1);
    check({v.name, "_idx_held"}, 32'(best_idx_a), 32'(prev_idx));
    check({v.name, "_cost_held"}, 32'(best_cost_a), 32'(prev_cost));
    for (int c = 0; c < 27; c++) begin
      for (int t = 0; t < 3; t++) begin
        if (v.gaps) begin
          repeat ($urandom_range(0, 2)) begin
            ce        = 1'($urandom_range(0, 1));
            din_valid = ce ? 1'b0 : 1'($urandom_range(0, 1));
            din       = 22'($urandom);
            start     = ($urandom_range(0, 3) == 0);
            step();
          end
          start = 1'b0;
        end
        ce = 1'b1; din_valid = 1'b1; din = term_val(v.kind, c, t);
        step();
      end
    end
    din_valid = 1'b0; din = '0;
    check({v.name, "_done_a"}, 32'(done_a), 32'd1);
    check({v.name, "_done_b"}, 32'(done_b), 32'd1);
    check({v.name, "_busy_low"}, 32'(busy_a), 32'd0);
    check({v.name, "_idx_a"}, 32'(best_idx_a), 32'(v.exp_idx));
    check({v.name, "_cost_a"}, 32'(best_cost_a), 32'(v.exp_cost));
    check({v.name, "_idx_b"}, 32'(best_idx_b), 32'(v.exp_idx));
    check({v.name, "_cost_b"}, 32'(best_cost_b), 32'(v.exp_cost_b));
    if (v.gaps) begin
      ce = 1'b0;
      step();
      check({v.name, "_done_hold_ce0"}, 32'(done_a), 32'd1);
      ce = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      check({v.name, "_start_in_done_ignored"}, 32'(state_dbg_a), 32'd0);
    end else begin
      step();
    end
    check({v.name, "_done_fell"}, 32'(done_a), 32'd0);
    step();
    check({v.name, "_idle_busy"}, 32'(busy_a), 32'd0);
    check({v.name, "_one_done_pulse"}, 32'(done_cnt), 32'd1);
    prev_idx  = v.exp_idx;
    prev_cost = v.exp_cost;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    vecs[0] = '{"ramp",    K_RAMP,    1'b0, 26, 1,       1};
    vecs[1] = '{"signed",  K_SIGNED,  1'b0, 5,  2,       2};
    vecs[2] = '{"tie",     K_TIE,     1'b0, 3,  4,       4};
    vecs[3] = '{"extreme", K_EXTREME, 1'b0, 0,  6291456, 4194303};
    vecs[4] = '{"gaps",    K_RAMP,    1'b1, 26, 1,       1};

    reset = 1'b0; ce = 1'b0; start = 1'b0; din_valid = 1'b0; din = '0;
    prev_idx = 0; prev_cost = 0;
    #12;
    check("rst_busy",  32'(busy_a),      32'd0);
    check("rst_done",  32'(done_a),      32'd0);
    check("rst_idx",   32'(best_idx_a),  32'd0);
    check("rst_cost",  32'(best_cost_a), 32'd0);
    check("rst_state", 32'(state_dbg_a), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // din_valid while in IDLE must be ignored.
    ce = 1'b1; din_valid = 1'b1; din = 22'd5;
    step();
    check("idle_din_ignored", 32'(state_dbg_a), 32'd0);
    din_valid = 1'b0;

    for (int i = 0; i < 5; i++) run_eval(vecs[i]);

    // Reset in the middle of candidate 10.
    ce = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 31; n++) begin
      din_valid = 1'b1; din = term_val(K_RAMP, n / 3, n % 3);
      step();
    end
    din_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("midrst_busy",   32'(busy_a),      32'd0);
    check("midrst_done",   32'(done_a),      32'd0);
    check("midrst_idx",    32'(best_idx_a),  32'd0);
    check("midrst_cost",   32'(best_cost_a), 32'd0);
    check("midrst_cost_b", 32'(best_cost_b), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    prev_idx = 0; prev_cost = 0;
    run_eval('{"post_rst", K_RAMP, 1'b0, 26, 1, 1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mpccore_cost_argmin.md
# mpccore_cost_argmin

Cost-evaluation stage directly downstream of the MPC core's 16s×6ns→22-bit weighted-error multiplier. It consumes the multiplier's signed 22-bit weighted error terms and accumulates their absolute values per candidate switching vector. It then selects the candidate with the minimum cost and reports its index to the NPC switching-state logic once per 20 kHz control period.

## Interface
- DIN_WIDTH, 22, width of the signed weighted-error input (multiplier output width).
- TERMS, 3, error terms per candidate (alpha current, beta current, neutral-point voltage).
- NUM_CAND, 27, candidate vectors per period (3-level NPC).
- ACC_WIDTH, 26, unsigned cost accumulator width.
- IDX_WIDTH, 5, candidate index width.

- clk  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset; one clock; polarity and synchronicity fixed.
- ce  in  1  clock enable, shared with the multiplier; ce=0 freezes all state and outputs.
- start  in  1  begin a new evaluation; sampled only in IDLE with ce=1.
- din_valid  in  1  din carries a valid term this cycle.
- din  in  DIN_WIDTH  signed weighted error term.
- busy  out  1  high from the accepted start until completion.
- done  out  1  single ce-cycle pulse when a result is published.
- best_idx  out  IDX_WIDTH  index of the minimum-cost candidate.
- best_cost  out  ACC_WIDTH  cost of that candidate.

## Operation
- FSM states are IDLE, ACC and DONE. Reset enters IDLE.
- **IDLE → ACC** on start=1 with ce=1. This clears the accumulator, term counter and candidate counter, and sets busy=1.
- **In ACC**, each cycle with ce=1 and din_valid=1 accepts one term: acc_next = acc + |din|.
  - |din| is formed at DIN_WIDTH+1 bits unsigned, so |−2^21| = 2^21 is exact.
  - The sum saturates at 2^ACC_WIDTH−1 and never wraps.
- **Candidate completion:** when the accepted term is term TERMS−1, acc_next is compared against the running best in the same cycle.
  - Candidate 0 unconditionally initialises the best.
  - Later candidates replace the best only if strictly less. Ties keep the lower index.
  - The accumulator then clears and the candidate counter increments.
- **ACC → DONE** when candidate NUM_CAND−1 completes. In that cycle best_idx and best_cost are updated from the final comparison result.
- **DONE → IDLE** after one ce cycle. done=1 and busy=0 while in DONE.
- Cycles with din_valid=0 in ACC are gaps with no state change. din_valid in IDLE or DONE is ignored.
- start while busy or in DONE is ignored.
- best_idx and best_cost change only at completion and hold until the next completion.
- Reset asserted mid-operation clears everything immediately. No done pulse is produced for the aborted run.

## Timing
- Reset values: busy=0, done=0, best_idx=0, best_cost=0, state IDLE, all counters and accumulator 0.
- The start edge registers busy=1. The first term is accepted from the following cycle.
- Latency: done rises in the ce cycle after the edge that accepts the last (NUM_CAND·TERMS-th) term. best_idx and best_cost are valid in that same cycle.
- Minimum period with no gaps: 1 (start) + 81 (terms) + 1 (DONE) = 83 ce cycles.
- ce=0 stretches every state. A done pulse lasts exactly one ce=1 cycle.
- No back-pressure toward the upstream multiplier. Upstream must not present more than NUM_CAND·TERMS valid terms per start.

## Test plan
- **Ramp:** candidate k gets terms {27−k, 0, 0}, no gaps → done at cycle 83, best_idx=26, best_cost=1.
- **Signed input:** candidate 5 gets {−1, +1, 0}; all others {10, 0, 0} → best_idx=5, best_cost=2.
- **Tie:** candidates 3 and 7 get {2, −2, 0}; others {100, 0, 0} → best_idx=3, best_cost=4.
- **Extremes:** every din = −2097152 → best_idx=0, best_cost=6291456, with no wrap.
  - Repeat with ACC_WIDTH=22 → best_cost saturates at 4194303.
- **Gaps and ignored start:** random din_valid and ce gaps, with start pulsed while busy → results identical to the gap-free run. Exactly one done pulse; busy low afterwards.
- **Reset mid-run:** drive reset low during candidate 10 → busy=0, done=0, best_idx=0, best_cost=0 immediately. A subsequent start plus the ramp stimulus yields best_idx=26.
